serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor. It computes `a - b` one bit per clock using a ripple-borrow register, and reports the difference and a borrow-out. It is the inverse-direction companion to the registered adder in the arithmetic datapath, and shares its operand width and clock/reset scheme. A start/ready/done handshake lets a controller issue one subtraction at a time.

---
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock through a ripple-borrow flop.
// Define SERIAL_SUB_SATURATE_EN to clamp diff to zero whenever the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH = 3
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] resShift;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             brNext;

    // One full-subtractor slice on the operand LSBs; the new bit enters the result from the top
    always_comb begin
        d        = areg[0] ^ breg[0] ^ br;
        brNext   = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & br);
        resShift = res >> 1;
        resShift[WIDTH-1] = d;
    end

    assign ready = (state == IDLE);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state  <= IDLE;
            areg   <= '0;
            breg   <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res  <= resShift;
                    areg <= areg >> 1;
                    breg <= breg >> 1;
                    br   <= brNext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef SERIAL_SUB_SATURATE_EN
                    diff <= br ? '0 : res;
`else
                    diff <= res;
`endif
                    borrow <= br;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a cycle model predicts acceptance, done timing and results.
module tb_serial_subtractor;

    localparam int WIDTH = 3;

    logic             iclk = 1'b0;
    logic             irst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             br;
    } exp_t;

    exp_t             expQ[$];
    int               errors = 0;
    int               checks = 0;
    int               mcnt = 0;
    int               acceptCount = 0;
    int               cyc = 0;
    int               prevDone = 0;
    bit               expDone = 0;
    bit               qUnderflow = 0;
    bit               mdlValid = 0;
    bit               heldMode = 0;
    logic [WIDTH-1:0] lastDiff = '0;
    logic             lastBorrow = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .iclk   (iclk),
        .irst   (irst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .diff   (diff),
        .borrow (borrow),
        .done   (done)
    );

    always #5 iclk = ~iclk;

    function automatic exp_t refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        e.br = (x < y);
        e.d  = x - y;
`ifdef SERIAL_SUB_SATURATE_EN
        if (e.br) e.d = '0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference timing: accept at edge N, done visible after edge N+WIDTH+1, idle again from then
    always @(posedge iclk) begin
        exp_t e;
        cyc++;
        expDone    = 0;
        qUnderflow = 0;
        if (irst) begin
            mdlValid   = 1;
            mcnt       = 0;
            expQ.delete();
            lastDiff   = '0;
            lastBorrow = 1'b0;
        end else if (mdlValid) begin
            if (mcnt != 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    expDone = 1;
                    if (expQ.size() == 0) begin
                        qUnderflow = 1;
                    end else begin
                        e          = expQ.pop_front();
                        lastDiff   = e.d;
                        lastBorrow = e.br;
                    end
                end
            end else if (start) begin
                expQ.push_back(refModel(a, b));
                mcnt = WIDTH + 1;
                acceptCount++;
            end
        end
    end

    always @(negedge iclk) begin
        if (mdlValid) begin
            checkOutput("ready", int'(ready), int'(mcnt == 0));
            checkOutput("done", int'(done), int'(expDone));
            if (expDone && qUnderflow) checkOutput("queue_underflow", 1, 0);
            checkOutput("diff", int'(diff), int'(lastDiff));
            checkOutput("borrow", int'(borrow), int'(lastBorrow));
            if (done) begin
                if (heldMode && prevDone != 0) checkOutput("done_spacing", cyc - prevDone, WIDTH + 2);
                prevDone = cyc;
            end
        end
    end

    task automatic waitAccept(input int target);
        for (int i = 0; i < 20 && acceptCount < target; i++) begin
            @(posedge iclk);
            #1;
        end
        if (acceptCount < target) checkOutput("accept_timeout", acceptCount, target);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 30 && !(mcnt == 0 && expQ.size() == 0); i++) begin
            @(posedge iclk);
            #1;
        end
        if (!(mcnt == 0 && expQ.size() == 0)) checkOutput("idle_timeout", mcnt, 0);
        @(posedge iclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int target;
        target = acceptCount + 1;
        a      = x;
        b      = y;
        start  = 1'b1;
        waitAccept(target);
        start  = 1'b0;
    endtask

    initial begin
        int target;

        irst = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        irst = 1'b0;
        checkOutput("rst_ready", int'(ready), 1);
        checkOutput("rst_diff", int'(diff), 0);
        checkOutput("rst_borrow", int'(borrow), 0);
        checkOutput("rst_done", int'(done), 0);

        applyStimulus(3'd5, 3'd3);
        waitIdle();
        applyStimulus(3'd3, 3'd5);
        waitIdle();
        applyStimulus(3'd7, 3'd7);
        waitIdle();
        applyStimulus(3'd0, 3'd1);
        waitIdle();

        // start kept high through RUN/DONE with new operands: only the next IDLE edge takes them
        target = acceptCount + 1;
        a      = 3'd2;
        b      = 3'd1;
        start  = 1'b1;
        waitAccept(target);
        a      = 3'd6;
        b      = 3'd1;
        waitAccept(target + 1);
        a      = 3'd0;
        b      = 3'd0;
        start  = 1'b0;
        waitIdle();

        // Reset lands on the second RUN edge
        applyStimulus(3'd6, 3'd2);
        @(posedge iclk);
        #1;
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        checkOutput("abort_ready", int'(ready), 1);
        checkOutput("abort_diff", int'(diff), 0);
        checkOutput("abort_borrow", int'(borrow), 0);
        repeat (WIDTH + 3) @(posedge iclk);
        #1;

        heldMode = 1;
        prevDone = 0;
        start    = 1'b1;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                a      = WIDTH'(x);
                b      = WIDTH'(y);
                target = acceptCount + 1;
                waitAccept(target);
            end
        end
        start = 1'b0;
        a     = '0;
        b     = '0;
        waitIdle();
        heldMode = 0;

        checkOutput("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
